// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/control definitions: opcodes, IR field positions, fetch-state enum.
// Consumed by the fetch unit and the multi-cycle control FSM.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_B_TYPE = 6'b000100;
  localparam logic [5:0] OP_J_TYPE = 6'b000010;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JIDX_MSB  = 25;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection, purely combinational (0 cycles): jump > taken branch > PC+4.
// No handshake; result is sampled by the fetch unit only on retire.
module instr_fetch_unit_next_pc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;
  logic [31:0] imm_sext;
  logic        unused_opcode;

  assign unused_opcode = ^ir[OPC_MSB:OPC_LSB];

  always_comb begin
    pc_plus4 = pc + 32'd4;
    imm_sext = sext16(ir[IMM_MSB:IMM_LSB]);
    // All adds are modulo 2^32; wrap-around is intentional.
    if (jump) begin
      next_pc = {pc_plus4[31:28], ir[JIDX_MSB:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + {imm_sext[29:0], 2'b00};
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage owning PC/IR: 1 cycle min FETCH->instr_valid, waits on imem_ack and retire.
// Optional FETCH_TIMEOUT_EN adds a FETCH watchdog that parks in a sticky FAULT state.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [5:0]  Opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic [31:0] pc_plus4,
  input  logic        retire,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic        fetch_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  instr_fetch_unit_next_pc_calc u_next_pc_calc (
    .pc      (pc_q),
    .ir      (ir_q),
    .branch  (branch),
    .jump    (jump),
    .zero    (zero),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_FETCH: begin
        // An ack on the limit cycle still wins over the timeout.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_ISSUE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_ISSUE: begin
        if (retire) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign imem_req    = (state_q == ST_FETCH) && !Reset;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ST_ISSUE) && !Reset;
  assign Opcode      = ir_q[OPC_MSB:OPC_LSB];
  assign rs          = ir_q[RS_MSB:RS_LSB];
  assign rt          = ir_q[RT_MSB:RT_LSB];
  assign rd          = ir_q[RD_MSB:RD_LSB];
  assign funct       = ir_q[FUNCT_MSB:FUNCT_LSB];
  assign imm_sext    = sext16(ir_q[IMM_MSB:IMM_LSB]);
  assign pc_plus4    = pc_q + 32'd4;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_fault = (state_q == ST_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule
